// File: rtl/elbeth_writeback_stage.sv
// ELBETH RV32I writeback stage: retires MEM-stage instructions, waits for load data,
// aligns/extends it and drives the register file write port.
module elbeth_writeback_stage #(
   parameter int unsigned TIMEOUT   = 16,
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_valid,
   output logic                 mem_ready,
   input  logic [4:0]           mem_rd_addr,
   input  logic                 mem_rd_we,
   input  logic                 mem_is_load,
   input  logic [2:0]           mem_funct3,
   input  logic [31:0]          mem_alu_result,
   input  logic                 dmem_rsp_valid,
   input  logic [31:0]          dmem_rsp_data,
   output logic [4:0]           rd_addr,
   output logic [31:0]          rd_data,
   output logic                 ctrl_w_enable,
   output logic                 wb_load_fault,
   output logic                 wb_bus_error,
   output logic [CNT_WIDTH-1:0] wb_instret
);

   typedef enum logic {S_ACCEPT, S_WAIT} state_t;

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] LAST_WAIT = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t        state;
   logic [TW-1:0] wait_cnt;
   logic [4:0]    ld_rd;
   logic          ld_we;
   logic [2:0]    ld_funct3;
   logic [1:0]    ld_off;
   logic          load_fault;
   logic          timeout_hit;

   function automatic logic [31:0] align_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      b = d[8*off +: 8];
      h = d[16*off[1] +: 16];
      case (f3)
         3'b000:  align_load = {{24{b[7]}}, b};
         3'b001:  align_load = {{16{h[15]}}, h};
         3'b100:  align_load = {24'd0, b};
         3'b101:  align_load = {16'd0, h};
         default: align_load = d;
      endcase
   endfunction

   assign mem_ready = (state == S_ACCEPT);

   // Illegal funct3 encodings or a halfword/word access that is not naturally aligned.
   always_comb begin
      load_fault = 1'b0;
      case (mem_funct3)
         3'b011, 3'b110, 3'b111: load_fault = 1'b1;
         3'b001, 3'b101:         load_fault = mem_alu_result[0];
         3'b010:                 load_fault = |mem_alu_result[1:0];
         default:                load_fault = 1'b0;
      endcase
   end

   assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == LAST_WAIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_ACCEPT;
         wait_cnt      <= '0;
         ld_rd         <= '0;
         ld_we         <= 1'b0;
         ld_funct3     <= '0;
         ld_off        <= '0;
         rd_addr       <= '0;
         rd_data       <= '0;
         ctrl_w_enable <= 1'b0;
         wb_load_fault <= 1'b0;
         wb_bus_error  <= 1'b0;
         wb_instret    <= '0;
      end else begin
         // NOTE: non-blocking throughout; these pulse defaults are overridden below on events.
         ctrl_w_enable <= 1'b0;
         wb_load_fault <= 1'b0;
         case (state)
            S_ACCEPT: begin
               if (mem_valid) begin
                  if (!mem_is_load) begin
                     rd_addr       <= mem_rd_addr;
                     rd_data       <= mem_alu_result;
                     ctrl_w_enable <= mem_rd_we & (|mem_rd_addr);
                     wb_instret    <= wb_instret + 1'b1;
                  end else if (load_fault) begin
                     wb_load_fault <= 1'b1;
                  end else begin
                     ld_rd     <= mem_rd_addr;
                     ld_we     <= mem_rd_we;
                     ld_funct3 <= mem_funct3;
                     ld_off    <= mem_alu_result[1:0];
                     wait_cnt  <= '0;
                     state     <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // A response on the final wait edge takes priority over the timeout.
               if (dmem_rsp_valid) begin
                  rd_addr       <= ld_rd;
                  rd_data       <= align_load(ld_funct3, ld_off, dmem_rsp_data);
                  ctrl_w_enable <= ld_we & (|ld_rd);
                  wb_instret    <= wb_instret + 1'b1;
                  state         <= S_ACCEPT;
               end else if (timeout_hit) begin
                  wb_bus_error <= 1'b1;
                  state        <= S_ACCEPT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= S_ACCEPT;
         endcase
      end
   end

endmodule

// File: tb/tb_elbeth_writeback_stage.sv
// Directed self-checking bench for elbeth_writeback_stage: ALU retire, loads,
// faults, timeout, back-to-back issue and reset during a pending load.
module tb_elbeth_writeback_stage;

   logic        clk;
   logic        rst;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd_addr;
   logic        mem_rd_we;
   logic        mem_is_load;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_alu_result;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_data;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        ctrl_w_enable;
   logic        wb_load_fault;
   logic        wb_bus_error;
   logic [31:0] wb_instret;

   int checks   = 0;
   int failures = 0;

   elbeth_writeback_stage #(.TIMEOUT(16), .CNT_WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_valid     (mem_valid),
      .mem_ready     (mem_ready),
      .mem_rd_addr   (mem_rd_addr),
      .mem_rd_we     (mem_rd_we),
      .mem_is_load   (mem_is_load),
      .mem_funct3    (mem_funct3),
      .mem_alu_result(mem_alu_result),
      .dmem_rsp_valid(dmem_rsp_valid),
      .dmem_rsp_data (dmem_rsp_data),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .ctrl_w_enable (ctrl_w_enable),
      .wb_load_fault (wb_load_fault),
      .wb_bus_error  (wb_bus_error),
      .wb_instret    (wb_instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                        input logic ld, input logic [2:0] f3, input logic [31:0] a);
      mem_valid      = v;
      mem_rd_addr    = rd;
      mem_rd_we      = we;
      mem_is_load    = ld;
      mem_funct3     = f3;
      mem_alu_result = a;
   endtask

   // Issue a legal load, idle in S_WAIT for 'gap' cycles, then deliver 'data'.
   task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] data, input int gap,
                          input logic [31:0] exp_data, input logic [31:0] exp_ret);
      drive(1'b1, rd, 1'b1, 1'b1, f3, a);
      step();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      check({tag, " ready_low"}, 32'(mem_ready), 32'd0);
      check({tag, " no_we_on_accept"}, 32'(ctrl_w_enable), 32'd0);
      for (int i = 0; i < gap; i++) step();
      dmem_rsp_valid = 1'b1;
      dmem_rsp_data  = data;
      step();
      dmem_rsp_valid = 1'b0;
      dmem_rsp_data  = 32'd0;
      check({tag, " we"}, 32'(ctrl_w_enable), 32'd1);
      check({tag, " rd_addr"}, 32'(rd_addr), 32'(rd));
      check({tag, " rd_data"}, rd_data, exp_data);
      check({tag, " instret"}, wb_instret, exp_ret);
      check({tag, " ready_back"}, 32'(mem_ready), 32'd1);
   endtask

   initial begin
      rst            = 1'b1;
      dmem_rsp_valid = 1'b0;
      dmem_rsp_data  = 32'd0;
      drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      step();
      step();
      rst = 1'b0;
      check("rst rd_addr", 32'(rd_addr), 32'd0);
      check("rst rd_data", rd_data, 32'd0);
      check("rst we", 32'(ctrl_w_enable), 32'd0);
      check("rst fault", 32'(wb_load_fault), 32'd0);
      check("rst bus_err", 32'(wb_bus_error), 32'd0);
      check("rst instret", wb_instret, 32'd0);
      check("rst ready", 32'(mem_ready), 32'd1);

      // ALU op retiring to x5
      drive(1'b1, 5'd5, 1'b1, 1'b0, 3'd0, 32'h1234_5678);
      step();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      check("add we", 32'(ctrl_w_enable), 32'd1);
      check("add rd_addr", 32'(rd_addr), 32'd5);
      check("add rd_data", rd_data, 32'h1234_5678);
      check("add instret", wb_instret, 32'd1);
      step();
      check("add we_pulse", 32'(ctrl_w_enable), 32'd0);
      check("add data_hold", rd_data, 32'h1234_5678);

      // Loads: byte 2 of 0x80FF_7F01 is 0xFF, upper half is 0x80FF
      do_load("lb",  5'd3, 3'b000, 32'h0000_1002, 32'h80FF_7F01, 1, 32'hFFFF_FFFF, 32'd2);
      do_load("lbu", 5'd3, 3'b100, 32'h0000_1002, 32'h80FF_7F01, 1, 32'h0000_00FF, 32'd3);
      do_load("lh",  5'd4, 3'b001, 32'h0000_1002, 32'h80FF_7F01, 1, 32'hFFFF_80FF, 32'd4);
      do_load("lhu", 5'd4, 3'b101, 32'h0000_1000, 32'h80FF_7F01, 0, 32'h0000_7F01, 32'd5);
      do_load("lb0", 5'd6, 3'b000, 32'h0000_1000, 32'h80FF_7F81, 2, 32'hFFFF_FF81, 32'd6);

      // Faulting loads: misaligned LW, misaligned LH, illegal funct3
      drive(1'b1, 5'd8, 1'b1, 1'b1, 3'b010, 32'h0000_1001);
      step();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      check("lw_mis fault", 32'(wb_load_fault), 32'd1);
      check("lw_mis we", 32'(ctrl_w_enable), 32'd0);
      check("lw_mis instret", wb_instret, 32'd6);
      check("lw_mis ready", 32'(mem_ready), 32'd1);
      step();
      check("lw_mis fault_pulse", 32'(wb_load_fault), 32'd0);
      drive(1'b1, 5'd8, 1'b1, 1'b1, 3'b001, 32'h0000_1003);
      step();
      check("lh_mis fault", 32'(wb_load_fault), 32'd1);
      drive(1'b1, 5'd8, 1'b1, 1'b1, 3'b110, 32'h0000_1000);
      step();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      check("f3_110 fault", 32'(wb_load_fault), 32'd1);
      check("f3_110 ready", 32'(mem_ready), 32'd1);
      check("faults instret", wb_instret, 32'd6);

      // Response on the 16th wait edge still wins over the timeout
      do_load("lw_edge", 5'd7, 3'b010, 32'h0000_2000, 32'hCAFE_BABE, 15, 32'hCAFE_BABE, 32'd7);
      check("lw_edge no_err", 32'(wb_bus_error), 32'd0);

      // Timeout: no response for 16 wait cycles
      drive(1'b1, 5'd9, 1'b1, 1'b1, 3'b010, 32'h0000_2004);
      step();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      for (int i = 0; i < 15; i++) step();
      check("to before ready", 32'(mem_ready), 32'd0);
      check("to before err", 32'(wb_bus_error), 32'd0);
      step();
      check("to err", 32'(wb_bus_error), 32'd1);
      check("to ready", 32'(mem_ready), 32'd1);
      check("to we", 32'(ctrl_w_enable), 32'd0);
      check("to instret", wb_instret, 32'd7);
      dmem_rsp_valid = 1'b1;
      dmem_rsp_data  = 32'hDEAD_BEEF;
      step();
      dmem_rsp_valid = 1'b0;
      check("late_rsp we", 32'(ctrl_w_enable), 32'd0);
      check("late_rsp instret", wb_instret, 32'd7);
      check("late_rsp data", rd_data, 32'hCAFE_BABE);
      check("err sticky", 32'(wb_bus_error), 32'd1);

      // Three back-to-back ALU ops, middle one targets x0
      drive(1'b1, 5'd1, 1'b1, 1'b0, 3'd0, 32'h0000_0011);
      step();
      check("b2b1 we", 32'(ctrl_w_enable), 32'd1);
      check("b2b1 data", rd_data, 32'h0000_0011);
      check("b2b1 ready", 32'(mem_ready), 32'd1);
      drive(1'b1, 5'd0, 1'b1, 1'b0, 3'd0, 32'h0000_0022);
      step();
      check("b2b_x0 we", 32'(ctrl_w_enable), 32'd0);
      check("b2b_x0 instret", wb_instret, 32'd9);
      drive(1'b1, 5'd2, 1'b1, 1'b0, 3'd0, 32'h0000_0033);
      step();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      check("b2b3 we", 32'(ctrl_w_enable), 32'd1);
      check("b2b3 rd_addr", 32'(rd_addr), 32'd2);
      check("b2b3 data", rd_data, 32'h0000_0033);
      check("b2b3 instret", wb_instret, 32'd10);

      // Reset during S_WAIT, response arrives the cycle after
      drive(1'b1, 5'd9, 1'b1, 1'b1, 3'b010, 32'h0000_3000);
      step();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      check("rw waiting", 32'(mem_ready), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      dmem_rsp_valid = 1'b1;
      dmem_rsp_data  = 32'h5555_AAAA;
      step();
      dmem_rsp_valid = 1'b0;
      check("rw we", 32'(ctrl_w_enable), 32'd0);
      check("rw rd_addr", 32'(rd_addr), 32'd0);
      check("rw rd_data", rd_data, 32'd0);
      check("rw instret", wb_instret, 32'd0);
      check("rw bus_err", 32'(wb_bus_error), 32'd0);
      check("rw ready", 32'(mem_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
